// File: rtl/center_track_overlay.sv
// Tracks a per-frame target centre through a SEARCH/TRACK/HOLD filter and draws a
// box-and-crosshair overlay around the smoothed position on the outgoing video.
module center_track_overlay #(
  parameter int unsigned LOST_FRAMES = 8,
  parameter int unsigned BOX_HALF    = 16,
  parameter logic [23:0] TRACK_COLOR = 24'hFF0000,
  parameter logic [23:0] HOLD_COLOR  = 24'hFFFF00
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] Hcnt,
  input  logic [11:0] Vcnt,
  input  logic [11:0] center_h,
  input  logic [11:0] center_v,
  input  logic [23:0] rgb_in,
  output logic [23:0] rgb_out,
  output logic [11:0] track_h,
  output logic [11:0] track_v,
  output logic        locked
);

  localparam int unsigned LcW   = $clog2(LOST_FRAMES + 1) + 1;
  localparam logic [11:0] HMax  = 12'd639;
  localparam logic [11:0] VMax  = 12'd479;
  localparam logic [11:0] NoH   = 12'd320;
  localparam logic [11:0] NoV   = 12'd240;
  localparam logic [12:0] BoxW  = 13'(BOX_HALF);
  localparam logic [LcW-1:0] LostLim = LcW'(LOST_FRAMES);

  typedef enum logic [1:0] {StSearch, StTrack, StHold} state_e;

  state_e           state_q, state_d;
  logic [11:0]      track_h_q, track_h_d, track_v_q, track_v_d;
  logic [LcW-1:0]   lost_cnt_q, lost_cnt_d;
  logic             locked_q;
  logic [23:0]      rgb_q;

  logic tick, valid;

  // track += (center - track) >>> 2, clamped into the active area.
  function automatic logic [11:0] filt(input logic [11:0] c, input logic [11:0] t,
                                       input logic [11:0] maxv);
    logic signed [12:0] diff;
    logic signed [12:0] step;
    logic signed [13:0] sum;
    diff = $signed({1'b0, c}) - $signed({1'b0, t});
    step = diff >>> 2;
    sum  = $signed({2'b00, t}) + $signed({step[12], step});
    if (sum < 0) begin
      return 12'd0;
    end else if (sum > $signed({2'b00, maxv})) begin
      return maxv;
    end else begin
      return sum[11:0];
    end
  endfunction

  function automatic logic [11:0] clampv(input logic [11:0] c, input logic [11:0] maxv);
    return (c > maxv) ? maxv : c;
  endfunction

  assign tick  = (Hcnt == 12'd0) && (Vcnt == 12'd0);
  assign valid = !((center_h == NoH) && (center_v == NoV));

  always_comb begin
    state_d    = state_q;
    track_h_d  = track_h_q;
    track_v_d  = track_v_q;
    lost_cnt_d = lost_cnt_q;
    if (tick) begin
      unique case (state_q)
        StSearch: begin
          if (valid) begin
            state_d    = StTrack;
            track_h_d  = clampv(center_h, HMax);
            track_v_d  = clampv(center_v, VMax);
            lost_cnt_d = '0;
          end else begin
            track_h_d = NoH;
            track_v_d = NoV;
          end
        end
        StTrack: begin
          if (valid) begin
            track_h_d = filt(center_h, track_h_q, HMax);
            track_v_d = filt(center_v, track_v_q, VMax);
          end else begin
            state_d    = StHold;
            lost_cnt_d = LcW'(1);
          end
        end
        StHold: begin
          if (valid) begin
            state_d    = StTrack;
            track_h_d  = filt(center_h, track_h_q, HMax);
            track_v_d  = filt(center_v, track_v_q, VMax);
            lost_cnt_d = '0;
          end else if (lost_cnt_q == LostLim) begin
            state_d    = StSearch;
            track_h_d  = NoH;
            track_v_d  = NoV;
            lost_cnt_d = '0;
          end else begin
            lost_cnt_d = lost_cnt_q + LcW'(1);
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  // Signed 13-bit distances so a box near the frame edge clips instead of wrapping.
  logic signed [12:0] dh, dv;
  logic [12:0]        adh, adv;
  logic               in_area, in_box, on_edge, on_cross, overlay;
  logic [23:0]        rgb_d;

  always_comb begin
    dh       = $signed({1'b0, Hcnt}) - $signed({1'b0, track_h_q});
    dv       = $signed({1'b0, Vcnt}) - $signed({1'b0, track_v_q});
    adh      = dh[12] ? 13'(-dh) : 13'(dh);
    adv      = dv[12] ? 13'(-dv) : 13'(dv);
    in_area  = (Hcnt <= HMax) && (Vcnt <= VMax);
    in_box   = (adh <= BoxW) && (adv <= BoxW);
    on_edge  = (adh == BoxW) || (adv == BoxW);
    on_cross = (Hcnt == track_h_q) || (Vcnt == track_v_q);
    overlay  = locked_q && in_area && in_box && (on_edge || on_cross);
    rgb_d    = rgb_in;
    if (overlay) begin
      rgb_d = (state_q == StHold) ? HOLD_COLOR : TRACK_COLOR;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= StSearch;
      track_h_q  <= NoH;
      track_v_q  <= NoV;
      lost_cnt_q <= '0;
      locked_q   <= 1'b0;
      rgb_q      <= 24'h000000;
    end else begin
      state_q    <= state_d;
      track_h_q  <= track_h_d;
      track_v_q  <= track_v_d;
      lost_cnt_q <= lost_cnt_d;
      locked_q   <= (state_d != StSearch);
      rgb_q      <= rgb_d;
    end
  end

  assign rgb_out = rgb_q;
  assign track_h = track_h_q;
  assign track_v = track_v_q;
  assign locked  = locked_q;

endmodule
